cell_tx_arbiter: RTL and testbench

CELL_TX_ARBITER -- requirements
Module: cell_tx_arbiter

---
 rtl/cell_tx_arbiter_pkg.sv | 39 +++
 rtl/cell_pkt_counter.sv | 31 +++
 rtl/cell_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cell_tx_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_tx_arbiter_pkg.sv
// Shared types and constants for the cell TX arbiter and its benches.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - arbiter FSM state encoding
//   src_sel_t    - source select (FWD ring traffic / LOC BPM traffic)
//   axis_beat_t  - one AXI-stream beat (data, last, valid) as a packed bundle
//   MAGIC, PKT_WORDS - cell header constants for benches and future header checks
package cell_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_FWD = 2'd1,
    ST_GNT_LOC = 2'd2,
    ST_FLUSH   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_FWD = 1'b0,
    SRC_LOC = 1'b1
  } src_sel_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
  } axis_beat_t;

  // Cell header magic word and nominal BPM packet length in 32-bit words.
  localparam logic [15:0] MAGIC     = 16'hA5BE;
  localparam int          PKT_WORDS = 5;

  // The source that did not hold the previous grant; used to break ties.
  function automatic src_sel_t other_src(input src_sel_t s);
    return (s == SRC_FWD) ? SRC_LOC : SRC_FWD;
  endfunction

endpackage

// File: rtl/cell_pkt_counter.sv
// Packet event counter, either wrapping or saturating at all-ones.
// Latency: count updates on the clock edge after inc is sampled high.
// Backpressure: none; every inc pulse is counted (unless saturated).
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (count clears to 0)
//   inc        - count one event this cycle
//   cnt        - current count
module cell_pkt_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !(SAT && at_max)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cell_tx_arbiter.sv
// Two-source packet arbiter (ring forward vs local BPM) onto the cell TX stream.
// Latency: one cycle of grant latency from IDLE; beats then pass combinationally.
// Backpressure: m_tready is routed to the granted source only; the other waits.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   enable                  - allow new grants (a packet in flight always finishes)
//   fwd_t* / loc_t*         - input AXI streams (forwarded ring / local packets)
//   m_t*                    - output AXI stream toward the Aurora link
//   busy                    - arbiter not in IDLE
//   pkt_cnt_fwd/_loc        - completed packets per source (wrapping)
//   trunc_cnt               - truncated packets (saturating at 255)
module cell_tx_arbiter
  import cell_tx_arbiter_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [31:0]     fwd_tdata,
  input  logic            fwd_tlast,
  input  logic            fwd_tvalid,
  output logic            fwd_tready,
  input  logic [31:0]     loc_tdata,
  input  logic            loc_tlast,
  input  logic            loc_tvalid,
  output logic            loc_tready,
  output logic [31:0]     m_tdata,
  output logic            m_tlast,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            busy,
  output logic [CNTW-1:0] pkt_cnt_fwd,
  output logic [CNTW-1:0] pkt_cnt_loc,
  output logic [7:0]      trunc_cnt
);

  localparam int BCW = $clog2(MAX_WORDS + 1);

  arb_state_t     state;
  src_sel_t       grant;
  src_sel_t       last_grant;
  src_sel_t       nxt_src;
  logic [BCW-1:0] beat_cnt;
  logic           rst_done;

  axis_beat_t     sel;
  logic           in_gnt;
  logic           in_flush;
  logic           src_rdy;
  logic           xfer;
  logic           trunc_beat;
  logic           inc_fwd;
  logic           inc_loc;
  logic           inc_trunc;

  // Output mux, driven by the grant register.
  always_comb begin
    sel.tdata  = fwd_tdata;
    sel.tlast  = fwd_tlast;
    sel.tvalid = fwd_tvalid;
    if (grant == SRC_LOC) begin
      sel.tdata  = loc_tdata;
      sel.tlast  = loc_tlast;
      sel.tvalid = loc_tvalid;
    end
  end

  assign in_gnt   = (state == ST_GNT_FWD) || (state == ST_GNT_LOC);
  assign in_flush = (state == ST_FLUSH);

  // Last permitted beat of an over-long packet: close it on the link side.
  assign trunc_beat = in_gnt && (beat_cnt == BCW'(MAX_WORDS - 1)) && !sel.tlast;

  assign m_tvalid = in_gnt && sel.tvalid;
  assign m_tdata  = in_gnt ? sel.tdata : '0;
  assign m_tlast  = in_gnt && (sel.tlast || trunc_beat);

  // While flushing, the granted source is drained regardless of the link.
  assign src_rdy    = in_gnt ? m_tready : in_flush;
  assign fwd_tready = src_rdy && (grant == SRC_FWD);
  assign loc_tready = src_rdy && (grant == SRC_LOC);
  assign xfer       = sel.tvalid && src_rdy;

  assign busy = (state != ST_IDLE);

  assign inc_fwd   = in_gnt && xfer && sel.tlast && (grant == SRC_FWD);
  assign inc_loc   = in_gnt && xfer && sel.tlast && (grant == SRC_LOC);
  assign inc_trunc = xfer && trunc_beat;

  // Request decode for IDLE: on a tie, the source that did not go last wins.
  always_comb begin
    nxt_src = SRC_LOC;
    if (fwd_tvalid && loc_tvalid) begin
      nxt_src = other_src(last_grant);
    end else if (fwd_tvalid) begin
      nxt_src = SRC_FWD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= SRC_FWD;
      last_grant <= SRC_LOC;
      beat_cnt   <= '0;
      rst_done   <= 1'b0;
    end else begin
      // rst_done holds off granting for the first edge after reset release,
      // so request inputs still settling from reset cannot win a grant.
      rst_done <= 1'b1;
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (enable && rst_done && (fwd_tvalid || loc_tvalid)) begin
            grant <= nxt_src;
            state <= (nxt_src == SRC_FWD) ? ST_GNT_FWD : ST_GNT_LOC;
          end
        end
        ST_GNT_FWD, ST_GNT_LOC: begin
          if (xfer) begin
            if (sel.tlast) begin
              state      <= ST_IDLE;
              last_grant <= grant;
              beat_cnt   <= '0;
            end else if (trunc_beat) begin
              state    <= ST_FLUSH;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (xfer && sel.tlast) begin
            state      <= ST_IDLE;
            last_grant <= grant;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cell_pkt_counter #(.W(CNTW), .SAT(1'b0)) u_cnt_fwd (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_fwd),
    .cnt   (pkt_cnt_fwd)
  );

  cell_pkt_counter #(.W(CNTW), .SAT(1'b0)) u_cnt_loc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_loc),
    .cnt   (pkt_cnt_loc)
  );

  cell_pkt_counter #(.W(8), .SAT(1'b1)) u_cnt_trunc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_trunc),
    .cnt   (trunc_cnt)
  );

endmodule

// File: tb/tb_cell_tx_arbiter.sv
module tb_cell_tx_arbiter;
  import cell_tx_arbiter_pkg::*;

  localparam int MAXW = 8;
  localparam int CNTW = 16;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [31:0] fwd_tdata, loc_tdata, m_tdata;
  logic        fwd_tlast, fwd_tvalid, fwd_tready;
  logic        loc_tlast, loc_tvalid, loc_tready;
  logic        m_tlast, m_tvalid, m_tready, busy;
  logic [CNTW-1:0] pkt_cnt_fwd, pkt_cnt_loc;
  logic [7:0]  trunc_cnt;

  always #5 clk = ~clk;

  cell_tx_arbiter #(.MAX_WORDS(MAXW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fwd_tdata(fwd_tdata), .fwd_tlast(fwd_tlast), .fwd_tvalid(fwd_tvalid), .fwd_tready(fwd_tready),
    .loc_tdata(loc_tdata), .loc_tlast(loc_tlast), .loc_tvalid(loc_tvalid), .loc_tready(loc_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .pkt_cnt_fwd(pkt_cnt_fwd), .pkt_cnt_loc(pkt_cnt_loc), .trunc_cnt(trunc_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Source beat queues (what each source still has to send).
  logic [31:0] fq_dat[$], lq_dat[$];
  bit          fq_lst[$], lq_lst[$];
  bit          f_sop, l_sop;
  // Packet records for the reference model.
  int          f_len[$], l_len[$];
  logic [31:0] f_pd[$], l_pd[$];
  // Captured output beats.
  logic [31:0] o_dat[$];
  bit          o_lst[$];
  int          o_cyc[$];
  // Per-cycle trace.
  bit          t_vld[$], t_mrdy[$], t_frdy[$], t_lrdy[$], t_busy[$];
  logic [31:0] t_dat[$];
  // Expected stream from the model.
  logic [31:0] ex_dat[$];
  bit          ex_lst[$];
  int          ex_cf, ex_cl, ex_tr;

  int gap_pct = 0;
  int tready_mode = 0;  // 0: always 1, 1: random, 2: toggle from first valid
  int tog_k = -1;

  function automatic logic [31:0] tagw(input bit is_loc, input int tag, input int b);
    logic [3:0] hi;
    hi = is_loc ? 4'h1 : 4'hF;
    return {hi, tag[11:0], b[15:0]};
  endfunction

  task automatic add_pkt(input bit is_loc, input int len, input bit rnd, input int tag);
    logic [31:0] d;
    for (int b = 0; b < len; b++) begin
      d = rnd ? $urandom : tagw(is_loc, tag, b);
      if (is_loc) begin
        lq_dat.push_back(d); lq_lst.push_back(b == len - 1); l_pd.push_back(d);
      end else begin
        fq_dat.push_back(d); fq_lst.push_back(b == len - 1); f_pd.push_back(d);
      end
    end
    if (is_loc) l_len.push_back(len); else f_len.push_back(len);
  endtask

  task automatic clear_bench();
    fq_dat.delete(); fq_lst.delete(); lq_dat.delete(); lq_lst.delete();
    f_len.delete(); l_len.delete(); f_pd.delete(); l_pd.delete();
    o_dat.delete(); o_lst.delete(); o_cyc.delete();
    t_vld.delete(); t_mrdy.delete(); t_frdy.delete(); t_lrdy.delete(); t_busy.delete(); t_dat.delete();
    f_sop = 1'b1; l_sop = 1'b1; tog_k = -1; cyc = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b1; m_tready = 1'b0;
    fwd_tdata = '0; fwd_tlast = 1'b0; fwd_tvalid = 1'b0;
    loc_tdata = '0; loc_tlast = 1'b0; loc_tvalid = 1'b0;
    clear_bench();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    bit f_fire, l_fire;
    if (fq_dat.size() > 0) begin
      fwd_tdata = fq_dat[0]; fwd_tlast = fq_lst[0];
      fwd_tvalid = f_sop || (int'($urandom_range(0, 99)) >= gap_pct);
    end else begin
      fwd_tdata = '0; fwd_tlast = 1'b0; fwd_tvalid = 1'b0;
    end
    if (lq_dat.size() > 0) begin
      loc_tdata = lq_dat[0]; loc_tlast = lq_lst[0];
      loc_tvalid = l_sop || (int'($urandom_range(0, 99)) >= gap_pct);
    end else begin
      loc_tdata = '0; loc_tlast = 1'b0; loc_tvalid = 1'b0;
    end
    #1;
    case (tready_mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      default: begin
        if (m_tvalid && tog_k < 0) tog_k = 0;
        m_tready = (tog_k < 0) ? 1'b1 : ((tog_k % 2) == 0);
        if (tog_k >= 0) tog_k++;
      end
    endcase
    #1;
    t_vld.push_back(m_tvalid); t_mrdy.push_back(m_tready); t_frdy.push_back(fwd_tready);
    t_lrdy.push_back(loc_tready); t_busy.push_back(busy); t_dat.push_back(m_tdata);
    f_fire = fwd_tvalid && fwd_tready;
    l_fire = loc_tvalid && loc_tready;
    if (m_tvalid && m_tready) begin
      o_dat.push_back(m_tdata); o_lst.push_back(m_tlast); o_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (f_fire) begin f_sop = fq_lst[0]; void'(fq_dat.pop_front()); void'(fq_lst.pop_front()); end
    if (l_fire) begin l_sop = lq_lst[0]; void'(lq_dat.pop_front()); void'(lq_lst.pop_front()); end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_drain(input int budget, output bit tmo);
    int n = 0;
    while ((fq_dat.size() > 0 || lq_dat.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    tmo = (n >= budget);
  endtask

  // Packet-level model: alternate on contention, truncate at MAXW, count.
  task automatic model();
    int pf = 0, pl = 0, of = 0, ol = 0, len, n;
    bit last_loc = 1'b1, pick_loc;
    ex_dat.delete(); ex_lst.delete(); ex_cf = 0; ex_cl = 0; ex_tr = 0;
    while (pf < f_len.size() || pl < l_len.size()) begin
      if (pf < f_len.size() && pl < l_len.size()) pick_loc = !last_loc;
      else pick_loc = (pl < l_len.size());
      len = pick_loc ? l_len[pl] : f_len[pf];
      n = (len > MAXW) ? MAXW : len;
      for (int b = 0; b < n; b++) begin
        ex_dat.push_back(pick_loc ? l_pd[ol + b] : f_pd[of + b]);
        ex_lst.push_back(b == n - 1);
      end
      if (len > MAXW) begin if (ex_tr < 255) ex_tr++; end
      else if (pick_loc) ex_cl++;
      else ex_cf++;
      if (pick_loc) begin ol += len; pl++; end else begin of += len; pf++; end
      last_loc = pick_loc;
    end
  endtask

  task automatic test_reset();
    bit tmo;
    rst_n = 1'b0; enable = 1'b1; m_tready = 1'b1;
    fwd_tvalid = 1'b1; loc_tvalid = 1'b1; fwd_tdata = 32'hDEADBEEF; loc_tdata = 32'h12345678;
    fwd_tlast = 1'b0; loc_tlast = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0) begin failures++; $display("FAIL reset_m_tdata got=%0h exp=0", m_tdata); end
    checks++; if ({fwd_tready, loc_tready, m_tlast, busy} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {fwd_tready, loc_tready, m_tlast, busy}); end
    checks++; if ({pkt_cnt_fwd, pkt_cnt_loc, trunc_cnt} !== '0) begin failures++;
      $display("FAIL reset_counters got=%0h/%0h/%0h exp=0", pkt_cnt_fwd, pkt_cnt_loc, trunc_cnt); end
    clear_bench();
    add_pkt(1'b0, 1, 1'b0, 0);
    add_pkt(1'b1, 1, 1'b0, 0);
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL first_edge_no_grant busy got=%0b exp=0", busy); end
    step();
    checks++; if ({busy, fwd_tready, loc_tready} !== 3'b110) begin failures++;
      $display("FAIL second_edge_grant_fwd busy/frdy/lrdy got=%b exp=110", {busy, fwd_tready, loc_tready}); end
    checks++; if (m_tdata !== tagw(1'b0, 0, 0) || m_tlast !== 1'b1) begin failures++;
      $display("FAIL second_edge_data got=%0h/%0b exp=%0h/1", m_tdata, m_tlast, tagw(1'b0, 0, 0)); end
    run_drain(50, tmo);
    checks++; if (tmo || o_dat.size() != 2) begin failures++; $display("FAIL single_beat_drain tmo=%0b beats=%0d exp=2", tmo, o_dat.size()); end
    else begin
      checks++; if (o_dat[1] !== tagw(1'b1, 0, 0) || o_cyc[1] != o_cyc[0] + 2) begin failures++;
        $display("FAIL single_beat_regrant got=%0h gap=%0d exp=%0h gap=2", o_dat[1], o_cyc[1] - o_cyc[0], tagw(1'b1, 0, 0)); end
    end
  endtask

  task automatic test_tie();
    bit tmo;
    apply_reset();
    add_pkt(1'b0, PKT_WORDS, 1'b0, 0);
    add_pkt(1'b1, PKT_WORDS, 1'b0, 0);
    run_drain(100, tmo);
    checks++; if (tmo || o_dat.size() != 2 * PKT_WORDS) begin failures++;
      $display("FAIL tie_beats tmo=%0b got=%0d exp=%0d", tmo, o_dat.size(), 2 * PKT_WORDS); end
    else begin
      for (int i = 0; i < 2 * PKT_WORDS; i++) begin
        checks++;
        if (o_dat[i] !== tagw(i >= PKT_WORDS, 0, i % PKT_WORDS) || o_lst[i] !== (i % PKT_WORDS == PKT_WORDS - 1)) begin
          failures++; $display("FAIL tie_beat%0d got=%0h/%0b exp=%0h", i, o_dat[i], o_lst[i], tagw(i >= PKT_WORDS, 0, i % PKT_WORDS));
        end
      end
      checks++; if (o_cyc[PKT_WORDS] != o_cyc[PKT_WORDS - 1] + 2) begin failures++;
        $display("FAIL tie_gap got=%0d exp=2", o_cyc[PKT_WORDS] - o_cyc[PKT_WORDS - 1]); end
    end
    checks++; if (pkt_cnt_fwd !== 16'd1 || pkt_cnt_loc !== 16'd1 || trunc_cnt !== 8'd0) begin failures++;
      $display("FAIL tie_counts got=%0d/%0d/%0d exp=1/1/0", pkt_cnt_fwd, pkt_cnt_loc, trunc_cnt); end
  endtask

  task automatic test_alternation();
    bit tmo;
    logic [3:0] exp_src[8];
    logic [3:0] got;
    exp_src = '{4'hF, 4'h1, 4'hF, 4'h1, 4'hF, 4'h1, 4'hF, 4'hF};
    apply_reset();
    for (int p = 0; p < 5; p++) add_pkt(1'b0, PKT_WORDS, 1'b0, p);
    for (int p = 0; p < 3; p++) add_pkt(1'b1, PKT_WORDS, 1'b0, p);
    run_drain(300, tmo);
    checks++; if (tmo || o_dat.size() != 8 * PKT_WORDS) begin failures++;
      $display("FAIL alt_beats tmo=%0b got=%0d exp=%0d", tmo, o_dat.size(), 8 * PKT_WORDS); end
    else begin
      for (int p = 0; p < 8; p++) begin
        got = o_dat[p * PKT_WORDS][31:28];
        checks++; if (got !== exp_src[p]) begin failures++; $display("FAIL alt_order pkt%0d got=%0h exp=%0h", p, got, exp_src[p]); end
      end
    end
    checks++; if (pkt_cnt_fwd !== 16'd5 || pkt_cnt_loc !== 16'd3) begin failures++;
      $display("FAIL alt_counts got=%0d/%0d exp=5/3", pkt_cnt_fwd, pkt_cnt_loc); end
  endtask

  task automatic test_stall();
    bit tmo;
    int first = -1;
    apply_reset();
    tready_mode = 2;
    add_pkt(1'b1, PKT_WORDS, 1'b0, 7);
    run_drain(100, tmo);
    tready_mode = 0;
    foreach (t_vld[i]) if (first < 0 && t_vld[i]) first = i;
    checks++; if (tmo || o_dat.size() != PKT_WORDS || first < 0) begin failures++;
      $display("FAIL stall_beats tmo=%0b got=%0d exp=%0d", tmo, o_dat.size(), PKT_WORDS); end
    else begin
      checks++; if (o_cyc[PKT_WORDS - 1] - first != 8) begin failures++;
        $display("FAIL stall_span got=%0d exp=8", o_cyc[PKT_WORDS - 1] - first); end
      for (int i = 0; i < PKT_WORDS; i++) begin
        checks++; if (o_dat[i] !== tagw(1'b1, 7, i)) begin failures++; $display("FAIL stall_data%0d got=%0h exp=%0h", i, o_dat[i], tagw(1'b1, 7, i)); end
      end
    end
    for (int i = 0; i < t_vld.size(); i++) begin
      if (t_busy[i]) begin
        checks++; if (t_lrdy[i] !== t_mrdy[i] || t_frdy[i] !== 1'b0) begin failures++;
          $display("FAIL stall_ready cyc%0d got lrdy=%0b frdy=%0b exp lrdy=%0b frdy=0", i, t_lrdy[i], t_frdy[i], t_mrdy[i]); end
      end
      if (i > 0 && t_vld[i - 1] && !t_mrdy[i - 1] && t_vld[i]) begin
        checks++; if (t_dat[i] !== t_dat[i - 1]) begin failures++;
          $display("FAIL stall_hold cyc%0d got=%0h exp=%0h", i, t_dat[i], t_dat[i - 1]); end
      end
    end
    checks++; if (pkt_cnt_loc !== 16'd1) begin failures++; $display("FAIL stall_count got=%0d exp=1", pkt_cnt_loc); end
  endtask

  task automatic test_truncation();
    bit tmo;
    int nlast = 0, ndisc = 0;
    apply_reset();
    add_pkt(1'b0, 12, 1'b0, 3);
    run_drain(200, tmo);
    checks++; if (tmo || o_dat.size() != MAXW) begin failures++;
      $display("FAIL trunc_beats tmo=%0b got=%0d exp=%0d", tmo, o_dat.size(), MAXW); end
    else begin
      foreach (o_lst[i]) if (o_lst[i]) nlast++;
      checks++; if (nlast != 1 || o_lst[MAXW - 1] !== 1'b1) begin failures++;
        $display("FAIL trunc_forced_last got=%0d lasts last_on_final=%0b exp=1/1", nlast, o_lst[MAXW - 1]); end
      checks++; if (o_dat[MAXW - 1] !== tagw(1'b0, 3, MAXW - 1)) begin failures++;
        $display("FAIL trunc_final_data got=%0h exp=%0h", o_dat[MAXW - 1], tagw(1'b0, 3, MAXW - 1)); end
    end
    foreach (t_frdy[i]) if (t_frdy[i] && !t_vld[i]) ndisc++;
    checks++; if (ndisc != 4) begin failures++; $display("FAIL trunc_discard got=%0d exp=4", ndisc); end
    checks++; if (trunc_cnt !== 8'd1 || pkt_cnt_fwd !== 16'd0 || busy !== 1'b0) begin failures++;
      $display("FAIL trunc_counts got=%0d/%0d busy=%0b exp=1/0/0", trunc_cnt, pkt_cnt_fwd, busy); end
  endtask

  task automatic test_enable();
    bit tmo;
    int n = 0;
    apply_reset();
    add_pkt(1'b1, PKT_WORDS, 1'b0, 9);
    while (o_dat.size() < 2 && n < 50) begin step(); n++; end
    checks++; if (n >= 50) begin failures++; $display("FAIL enable_start timeout got=%0d beats exp=2", o_dat.size()); end
    enable = 1'b0;
    add_pkt(1'b0, 3, 1'b0, 1);
    repeat (30) step();
    checks++; if (o_dat.size() != PKT_WORDS || pkt_cnt_loc !== 16'd1) begin failures++;
      $display("FAIL enable_finish got=%0d beats cnt=%0d exp=%0d/1", o_dat.size(), pkt_cnt_loc, PKT_WORDS); end
    checks++; if (busy !== 1'b0 || fq_dat.size() != 3 || pkt_cnt_fwd !== 16'd0) begin failures++;
      $display("FAIL enable_hold busy=%0b fwd_left=%0d cnt=%0d exp=0/3/0", busy, fq_dat.size(), pkt_cnt_fwd); end
    enable = 1'b1;
    run_drain(100, tmo);
    checks++; if (tmo || o_dat.size() != PKT_WORDS + 3 || pkt_cnt_fwd !== 16'd1) begin failures++;
      $display("FAIL enable_resume tmo=%0b beats=%0d cnt=%0d exp=%0d/1", tmo, o_dat.size(), pkt_cnt_fwd, PKT_WORDS + 3); end
    else begin
      checks++; if (o_dat[PKT_WORDS] !== tagw(1'b0, 1, 0)) begin failures++;
        $display("FAIL enable_resume_data got=%0h exp=%0h", o_dat[PKT_WORDS], tagw(1'b0, 1, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    int n = 0;
    apply_reset();
    add_pkt(1'b1, 2, 1'b0, 4);
    run_drain(50, tmo);
    checks++; if (tmo || pkt_cnt_loc !== 16'd1) begin failures++; $display("FAIL rstmid_pre got=%0d tmo=%0b exp=1", pkt_cnt_loc, tmo); end
    add_pkt(1'b0, 8, 1'b0, 5);
    while (o_dat.size() < 5 && n < 50) begin step(); n++; end
    checks++; if (n >= 50 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_setup beats=%0d busy=%0b exp=5/1", o_dat.size(), busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({m_tvalid, fwd_tready, loc_tready, m_tlast, busy} !== 5'b0 || m_tdata !== 32'h0) begin failures++;
      $display("FAIL rstmid_outputs got=%b data=%0h exp=00000/0", {m_tvalid, fwd_tready, loc_tready, m_tlast, busy}, m_tdata); end
    checks++; if ({pkt_cnt_fwd, pkt_cnt_loc, trunc_cnt} !== '0) begin failures++;
      $display("FAIL rstmid_counters got=%0d/%0d/%0d exp=0", pkt_cnt_fwd, pkt_cnt_loc, trunc_cnt); end
    @(negedge clk);
    clear_bench();
    rst_n = 1'b1;
    add_pkt(1'b0, 3, 1'b0, 6);
    run_drain(50, tmo);
    checks++; if (tmo || pkt_cnt_fwd !== 16'd1 || o_dat.size() != 3) begin failures++;
      $display("FAIL rstmid_after got=%0d beats cnt=%0d exp=3/1", o_dat.size(), pkt_cnt_fwd); end
  endtask

  task automatic test_random();
    bit tmo;
    int n;
    apply_reset();
    gap_pct = 25;
    tready_mode = 1;
    for (int p = 0; p < 30; p++) begin
      add_pkt(1'b0, $urandom_range(1, 12), 1'b1, 0);
      add_pkt(1'b1, $urandom_range(1, 12), 1'b1, 0);
    end
    model();
    run_drain(20000, tmo);
    gap_pct = 0;
    tready_mode = 0;
    checks++; if (tmo || o_dat.size() != ex_dat.size()) begin failures++;
      $display("FAIL rand_len tmo=%0b got=%0d exp=%0d", tmo, o_dat.size(), ex_dat.size()); end
    n = (o_dat.size() < ex_dat.size()) ? o_dat.size() : ex_dat.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (o_dat[i] !== ex_dat[i] || o_lst[i] !== ex_lst[i]) begin failures++;
        $display("FAIL rand_beat%0d got=%0h/%0b exp=%0h/%0b", i, o_dat[i], o_lst[i], ex_dat[i], ex_lst[i]); end
    end
    checks++; if (pkt_cnt_fwd !== CNTW'(ex_cf) || pkt_cnt_loc !== CNTW'(ex_cl) || trunc_cnt !== 8'(ex_tr)) begin failures++;
      $display("FAIL rand_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", pkt_cnt_fwd, pkt_cnt_loc, trunc_cnt, ex_cf, ex_cl, ex_tr); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_alternation();
    test_stall();
    test_truncation();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
